// File: rtl/sdram_refresh_pkg.sv
// Shared definitions for the SDRAM refresh scheduler: default timing
// parameters, debt counter width and the handshake FSM state encoding.
package sdram_refresh_pkg;

    localparam int unsigned REFRESH_PERIOD_DEF = 5;  // eclk ticks per refresh interval
    localparam int unsigned MAX_DEBT_DEF       = 8;  // owed refreshes before overflow
    localparam int unsigned URGENT_LEVEL_DEF   = 6;  // debt that ends postponement
    localparam int unsigned DEBT_W             = 4;  // width of the owed-refresh count

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POSTPONE,
        ST_REQUEST,
        ST_WAIT_ACK,
        ST_RELEASE
    } refresh_state_e;

endpackage : sdram_refresh_pkg

// File: rtl/sdram_refresh_sched_sync2.sv
// sync2: generic two-flop synchronizer with asynchronous active-low reset.
// Brings a single-bit level from a foreign clock domain into clk.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep these as two distinct flops; blocking would collapse the chain into one.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2

// File: rtl/sdram_refresh_sched.sv
// sdram_refresh_sched: counts refresh intervals on the E clock, tracks the
// number of owed refreshes and issues them to the clk-domain SDRAM
// controller over a four-phase req/ack handshake.
// Optional build macro RIDE_REFRESH_POSTPONE_EN: when defined, ram_busy
// postpones requests until the debt reaches URGENT_LEVEL; when undefined,
// ram_busy is ignored and requests issue as soon as any refresh is owed.
module sdram_refresh_sched
    import sdram_refresh_pkg::*;
#(
    parameter int unsigned REFRESH_PERIOD = REFRESH_PERIOD_DEF,
    parameter int unsigned MAX_DEBT       = MAX_DEBT_DEF,
    parameter int unsigned URGENT_LEVEL   = URGENT_LEVEL_DEF
) (
    input  logic              eclk,
    input  logic              refreshreset,
    input  logic              ram_busy,
    input  logic              refresh_ack,
    output logic              refresh_req,
    output logic              refresh_urgent,
    output logic [DEBT_W-1:0] refresh_debt,
    output logic              refresh_overflow
);

    localparam int unsigned       CNT_W       = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX    = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] DEBT_URGENT = DEBT_W'(URGENT_LEVEL);

    logic [CNT_W-1:0]  cnt_q;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              ovf_q, ovf_d;
    logic              req_q;
    refresh_state_e    state_q;
    logic              ack_s;
    logic              tick;
    logic              dec;
    logic              urgent;

    // The acknowledge comes from another clock domain.
    sync2 u_ack_sync (
        .clk   (eclk),
        .rst_n (refreshreset),
        .d_i   (refresh_ack),
        .q_o   (ack_s)
    );

`ifndef RIDE_REFRESH_POSTPONE_EN
    // Without postponement the controller's busy flag has no influence.
    logic unused_ram_busy;
    assign unused_ram_busy = ram_busy;
`endif

    assign tick   = (cnt_q == '0);
    assign dec    = (state_q == ST_WAIT_ACK);
    assign urgent = (debt_q >= DEBT_URGENT);

    // Interval down-counter; the cycle spent at zero is the refresh tick.
    always_ff @(posedge eclk or negedge refreshreset) begin
        if (!refreshreset) begin
            cnt_q <= CNT_RELOAD;
        end else if (tick) begin
            cnt_q <= CNT_RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Next debt: a tick adds one, a completed handshake removes one, both cancel.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick && !dec) begin
            if (debt_q == DEBT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + 1'b1;
            end
        end else if (dec && !tick) begin
            if (debt_q != '0) begin
                debt_d = debt_q - 1'b1;
            end
        end
    end

    // Debt and sticky overflow registers.
    always_ff @(posedge eclk or negedge refreshreset) begin
        if (!refreshreset) begin
            debt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            debt_q <= debt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Handshake FSM with a registered request, high only while in REQUEST.
    always_ff @(posedge eclk or negedge refreshreset) begin
        if (!refreshreset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A stale ack_s (e.g. after reset mid-handshake) holds us here.
                    if (debt_q != '0 && !ack_s) begin
`ifdef RIDE_REFRESH_POSTPONE_EN
                        if (ram_busy && !urgent) begin
                            state_q <= ST_POSTPONE;
                        end else begin
                            state_q <= ST_REQUEST;
                            req_q   <= 1'b1;
                        end
`else
                        state_q <= ST_REQUEST;
                        req_q   <= 1'b1;
`endif
                    end
                end
                ST_POSTPONE: begin
`ifdef RIDE_REFRESH_POSTPONE_EN
                    if (!ram_busy || urgent) begin
                        state_q <= ST_REQUEST;
                        req_q   <= 1'b1;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                ST_REQUEST: begin
                    if (ack_s) begin
                        state_q <= ST_WAIT_ACK;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT_ACK: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign refresh_req      = req_q;
    assign refresh_urgent   = urgent;
    assign refresh_debt     = debt_q;
    assign refresh_overflow = ovf_q;

endmodule : sdram_refresh_sched

// File: tb/tb_sdram_refresh_sched.sv
// Directed testbench for sdram_refresh_sched with default parameters.
// Inputs change and outputs are sampled on the falling edge of eclk; eN in
// tags means the falling edge after the N-th rising edge since reset release.
module tb_sdram_refresh_sched;
    import sdram_refresh_pkg::*;

    logic              eclk;
    logic              refreshreset;
    logic              ram_busy;
    logic              refresh_ack;
    logic              refresh_req;
    logic              refresh_urgent;
    logic [DEBT_W-1:0] refresh_debt;
    logic              refresh_overflow;

    logic ack_man;   // acknowledge driven directly by the stimulus
    logic ack_auto;  // acknowledge from the automatic responder
    logic auto_ack;  // selects the automatic responder
    int   acnt;
    int   checks;
    int   failures;

    assign refresh_ack = auto_ack ? ack_auto : ack_man;

    sdram_refresh_sched dut (
        .eclk             (eclk),
        .refreshreset     (refreshreset),
        .ram_busy         (ram_busy),
        .refresh_ack      (refresh_ack),
        .refresh_req      (refresh_req),
        .refresh_urgent   (refresh_urgent),
        .refresh_debt     (refresh_debt),
        .refresh_overflow (refresh_overflow)
    );

    initial begin
        eclk = 1'b0;
        forever #5 eclk = ~eclk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge eclk);
    endtask

    // Hold reset for two cycles and release it on a falling edge (e0).
    task automatic apply_reset();
        auto_ack     = 1'b0;
        ack_man      = 1'b0;
        ram_busy     = 1'b0;
        refreshreset = 1'b0;
        cyc(2);
        refreshreset = 1'b1;
    endtask

    // Automatic four-phase responder: raise ack three samples after req,
    // drop it once req has fallen.
    initial begin
        ack_auto = 1'b0;
        acnt     = 0;
        forever begin
            @(negedge eclk);
            #2;
            if (!auto_ack) begin
                ack_auto = 1'b0;
                acnt     = 0;
            end else if (!ack_auto && refresh_req) begin
                acnt++;
                if (acnt >= 3) begin
                    ack_auto = 1'b1;
                    acnt     = 0;
                end
            end else if (ack_auto && !refresh_req) begin
                ack_auto = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        auto_ack     = 1'b0;
        ack_man      = 1'b0;
        ram_busy     = 1'b0;
        refreshreset = 1'b0;

        // Reset state while reset is held.
        cyc(2);
        check("rst_req",      32'(refresh_req),      0);
        check("rst_urgent",   32'(refresh_urgent),   0);
        check("rst_debt",     32'(refresh_debt),     0);
        check("rst_overflow", 32'(refresh_overflow), 0);

        // First tick, first request and one automatic handshake.
        apply_reset();
        auto_ack = 1'b1;
        cyc(4);  check("s1_e4_debt",  32'(refresh_debt), 0);
                 check("s1_e4_req",   32'(refresh_req),  0);
        cyc(1);  check("s1_e5_debt",  32'(refresh_debt), 1);
                 check("s1_e5_req",   32'(refresh_req),  0);
        cyc(1);  check("s1_e6_req",   32'(refresh_req),  1);
        cyc(4);  check("s1_e10_req",  32'(refresh_req),  1);
                 check("s1_e10_debt", 32'(refresh_debt), 2);
        cyc(1);  check("s1_e11_req",  32'(refresh_req),  0);
                 check("s1_e11_debt", 32'(refresh_debt), 2);
        cyc(1);  check("s1_e12_debt", 32'(refresh_debt), 1);
        cyc(2);  check("s1_e14_req",  32'(refresh_req),  0);
        cyc(1);  check("s1_e15_req",  32'(refresh_req),  1);
                 check("s1_e15_debt", 32'(refresh_debt), 2);

        // Ack withheld: debt saturates at 8, the next tick sets overflow.
        apply_reset();
        cyc(10); check("s2_e10_debt", 32'(refresh_debt),     2);
                 check("s2_e10_req",  32'(refresh_req),      1);
        cyc(29); check("s2_e39_debt", 32'(refresh_debt),     7);
        cyc(1);  check("s2_e40_debt", 32'(refresh_debt),     8);
                 check("s2_e40_ovf",  32'(refresh_overflow), 0);
                 check("s2_e40_urg",  32'(refresh_urgent),   1);
        cyc(4);  check("s2_e44_ovf",  32'(refresh_overflow), 0);
        cyc(1);  check("s2_e45_ovf",  32'(refresh_overflow), 1);
                 check("s2_e45_debt", 32'(refresh_debt),     8);
        auto_ack = 1'b1;
        cyc(6);  check("s2_e51_debt", 32'(refresh_debt),     7);
                 check("s2_e51_req",  32'(refresh_req),      0);
                 check("s2_e51_ovf",  32'(refresh_overflow), 1);
        cyc(20); check("s2_e71_ovf",  32'(refresh_overflow), 1);

        // Controller busy throughout.
        apply_reset();
        ram_busy = 1'b1;
`ifdef RIDE_REFRESH_POSTPONE_EN
        cyc(6);  check("s3_e6_req",   32'(refresh_req),    0);
                 check("s3_e6_debt",  32'(refresh_debt),   1);
        cyc(23); check("s3_e29_req",  32'(refresh_req),    0);
                 check("s3_e29_debt", 32'(refresh_debt),   5);
                 check("s3_e29_urg",  32'(refresh_urgent), 0);
        cyc(1);  check("s3_e30_debt", 32'(refresh_debt),   6);
                 check("s3_e30_urg",  32'(refresh_urgent), 1);
                 check("s3_e30_req",  32'(refresh_req),    0);
        cyc(1);  check("s3_e31_req",  32'(refresh_req),    1);
`else
        cyc(6);  check("s3_e6_req",   32'(refresh_req),    1);
                 check("s3_e6_debt",  32'(refresh_debt),   1);
                 check("s3_e6_urg",   32'(refresh_urgent), 0);
        cyc(24); check("s3_e30_req",  32'(refresh_req),    1);
                 check("s3_e30_debt", 32'(refresh_debt),   6);
                 check("s3_e30_urg",  32'(refresh_urgent), 1);
`endif
        ram_busy = 1'b0;

        // Handshake completion lands on the tick at edge 20 with debt 3.
        apply_reset();
        cyc(16); check("s4_e16_req",  32'(refresh_req),      1);
                 check("s4_e16_debt", 32'(refresh_debt),     3);
        ack_man = 1'b1;
        cyc(3);  check("s4_e19_req",  32'(refresh_req),      0);
                 check("s4_e19_debt", 32'(refresh_debt),     3);
        cyc(1);  check("s4_e20_debt", 32'(refresh_debt),     3);
                 check("s4_e20_ovf",  32'(refresh_overflow), 0);
        cyc(5);  check("s4_e25_debt", 32'(refresh_debt),     4);
                 check("s4_e25_req",  32'(refresh_req),      0);

        // Spurious acknowledge pulse while idle with no debt.
        apply_reset();
        ack_man = 1'b1;
        cyc(2);  check("s5_e2_req",   32'(refresh_req),  0);
                 check("s5_e2_debt",  32'(refresh_debt), 0);
        ack_man = 1'b0;
        cyc(2);  check("s5_e4_req",   32'(refresh_req),  0);
                 check("s5_e4_debt",  32'(refresh_debt), 0);
        cyc(1);  check("s5_e5_debt",  32'(refresh_debt), 1);
                 check("s5_e5_req",   32'(refresh_req),  0);
        cyc(1);  check("s5_e6_req",   32'(refresh_req),  1);

        // Reset mid-handshake with ack left high.
        apply_reset();
        cyc(6);  check("s6_e6_req",   32'(refresh_req),  1);
        ack_man      = 1'b1;
        refreshreset = 1'b0;
        #1;
        check("s6_async_req",  32'(refresh_req),  0);
        check("s6_async_debt", 32'(refresh_debt), 0);
        cyc(1);
        refreshreset = 1'b1;
        cyc(12); check("s6_e12_req",  32'(refresh_req),  0);
                 check("s6_e12_debt", 32'(refresh_debt), 2);
        cyc(8);  check("s6_e20_req",  32'(refresh_req),  0);
                 check("s6_e20_debt", 32'(refresh_debt), 4);
        ack_man = 1'b0;
        cyc(2);  check("s6_e22_req",  32'(refresh_req),  0);
        cyc(1);  check("s6_e23_req",  32'(refresh_req),  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sdram_refresh_sched
